// File: rtl/parity_frame_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : parity_frame_checker_if
//  Brief    : Word-in / report-out handshake bundle for parity_frame_checker.
//             Report capture ports appear only when ERR_CAPTURE_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface parity_frame_checker_if #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
);
    localparam int EW = $clog2(FRAME_LEN + 1);
    localparam int IW = $clog2(FRAME_LEN);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             in_parity;
    logic             out_valid;
    logic             out_ready;
    logic [EW-1:0]    out_err_cnt;
    logic             out_frame_ok;
    logic [CNT_W-1:0] bad_frames;
`ifdef ERR_CAPTURE_EN
    logic [IW-1:0]    first_err_idx;
    logic [3:0]       first_err_data;
`endif

    modport master (
        output in_valid, in_data, in_parity, out_ready,
        input  in_ready, out_valid, out_err_cnt, out_frame_ok, bad_frames
`ifdef ERR_CAPTURE_EN
        , input first_err_idx, first_err_data
`endif
    );

    modport slave (
        input  in_valid, in_data, in_parity, out_ready,
        output in_ready, out_valid, out_err_cnt, out_frame_ok, bad_frames
`ifdef ERR_CAPTURE_EN
        , output first_err_idx, first_err_data
`endif
    );
endinterface
`default_nettype wire

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module   : parity_frame_checker
//  Brief    : Groups parity-protected nibbles into FRAME_LEN-word frames and
//             reports bad-word count per frame; optional first-error capture
//             enabled by defining ERR_CAPTURE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module parity_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               sync_clr,
    parity_frame_checker_if.slave   bus
);
    localparam int EW = $clog2(FRAME_LEN + 1);
    localparam int IW = $clog2(FRAME_LEN);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_COLLECT = 2'd1;
    localparam logic [1:0]       c_REPORT  = 2'd2;
    localparam logic [IW-1:0]    c_LAST    = IW'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] c_SAT     = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_live;
    logic             w_in_ready;
    logic             w_out_valid;
    logic [IW-1:0]    r_idx;
    logic [EW-1:0]    r_run_cnt;
    logic [EW-1:0]    r_err_cnt;
    logic             r_frame_ok;
    logic [CNT_W-1:0] r_bad_frames;

    logic             w_word_err;
    logic             w_accept;
    logic             w_final;
    logic             w_handshake;
    logic             w_first_now;
    logic [EW-1:0]    w_cnt_next;

    assign w_word_err  = ^{bus.in_data, bus.in_parity};
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_final     = (r_state == c_COLLECT) && (r_idx == c_LAST);
    assign w_handshake = w_out_valid && bus.out_ready;
    assign w_cnt_next  = r_run_cnt + {{(EW-1){1'b0}}, w_word_err};
    // The running count is zero exactly until the first bad word of a frame.
    assign w_first_now = w_word_err && (r_run_cnt == '0);

    // r_live keeps in_ready low for the first cycle out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= sync_clr ? c_IDLE : w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:    if (w_accept)              w_state_next = c_COLLECT;
            c_COLLECT: if (w_accept && w_final)   w_state_next = c_REPORT;
            c_REPORT:  if (w_handshake)           w_state_next = c_IDLE;
            default:                              w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            c_IDLE,
            c_COLLECT: w_in_ready  = r_live;
            c_REPORT:  w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_run_cnt    <= '0;
            r_err_cnt    <= '0;
            r_frame_ok   <= 1'b0;
            r_bad_frames <= '0;
        end else if (sync_clr) begin
            r_idx        <= '0;
            r_run_cnt    <= '0;
            r_err_cnt    <= '0;
            r_frame_ok   <= 1'b0;
            r_bad_frames <= '0;
        end else if (w_accept) begin
            r_run_cnt <= w_cnt_next;
            if (w_final) begin
                r_idx      <= '0;
                r_err_cnt  <= w_cnt_next;
                r_frame_ok <= (w_cnt_next == '0);
                if ((w_cnt_next != '0) && (r_bad_frames != c_SAT))
                    r_bad_frames <= r_bad_frames + 1'b1;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else if (w_handshake) begin
            r_run_cnt <= '0;
        end
    end

`ifdef ERR_CAPTURE_EN
    logic [IW-1:0] r_cap_idx;
    logic [3:0]    r_cap_data;
    logic [IW-1:0] r_first_idx;
    logic [3:0]    r_first_data;

    // r_cap_* hold the in-flight frame's first error; r_first_* the reported one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_idx    <= '0;
            r_cap_data   <= '0;
            r_first_idx  <= '0;
            r_first_data <= '0;
        end else if (sync_clr) begin
            r_cap_idx    <= '0;
            r_cap_data   <= '0;
            r_first_idx  <= '0;
            r_first_data <= '0;
        end else if (w_accept) begin
            if (w_final) begin
                r_first_idx  <= w_first_now ? r_idx       : r_cap_idx;
                r_first_data <= w_first_now ? bus.in_data : r_cap_data;
                r_cap_idx    <= '0;
                r_cap_data   <= '0;
            end else if (w_first_now) begin
                r_cap_idx  <= r_idx;
                r_cap_data <= bus.in_data;
            end
        end
    end

    assign bus.first_err_idx  = r_first_idx;
    assign bus.first_err_data = r_first_data;
`endif

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = w_out_valid;
    assign bus.out_err_cnt  = r_err_cnt;
    assign bus.out_frame_ok = r_frame_ok;
    assign bus.bad_frames   = r_bad_frames;
endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_parity_frame_checker
//  Brief    : Scoreboard bench; a wide-counter and a 2-bit-counter instance
//             share stimulus so saturation is observed alongside normal runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_parity_frame_checker;
    localparam int c_FL = 8;

    typedef struct {
        int err_cnt;
        int ok;
        int bf;
        int fidx;
        int fdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync_clr = 1'b0;
    always #5 clk = ~clk;

    parity_frame_checker_if #(.FRAME_LEN(c_FL), .CNT_W(8)) mif ();
    parity_frame_checker_if #(.FRAME_LEN(c_FL), .CNT_W(2)) sif ();

    assign sif.in_valid  = mif.in_valid;
    assign sif.in_data   = mif.in_data;
    assign sif.in_parity = mif.in_parity;
    assign sif.out_ready = mif.out_ready;

    parity_frame_checker #(.FRAME_LEN(c_FL), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .bus(mif.slave));
    parity_frame_checker #(.FRAME_LEN(c_FL), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .bus(sif.slave));

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         bf_model = 0;
    int         bp_mode = 0;
    bit         hs_pending = 0;
    logic [3:0] fd[c_FL];
    logic       fp[c_FL];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // out_ready policy: 0 = always ready, 1 = random, 2 = stalled.
    initial begin
        mif.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       mif.out_ready = 1'b1;
                1:       mif.out_ready = 1'($urandom_range(0, 1));
                default: mif.out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst_n || sync_clr) begin
            hs_pending = 0;
        end else if (hs_pending) begin
            chk("ready_after_hs", mif.in_ready, 1);
            chk("valid_drop_after_hs", mif.out_valid, 0);
            hs_pending = 0;
        end else if (mif.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_report", q.size(), 1);
            end else begin
                chk("err_cnt", mif.out_err_cnt, q[0].err_cnt);
                chk("frame_ok", mif.out_frame_ok, q[0].ok);
                chk("bad_frames", mif.bad_frames, (q[0].bf > 255) ? 255 : q[0].bf);
                chk("bad_frames_sat", sif.bad_frames, (q[0].bf > 3) ? 3 : q[0].bf);
                chk("in_ready_in_report", mif.in_ready, 0);
`ifdef ERR_CAPTURE_EN
                chk("first_err_idx", mif.first_err_idx, q[0].fidx);
                chk("first_err_data", mif.first_err_data, q[0].fdata);
`endif
                if (mif.out_ready) begin
                    void'(q.pop_front());
                    hs_pending = 1;
                end
            end
        end
    end

    task automatic send_word(input logic [3:0] d, input logic p);
        int t   = 0;
        bit rdy = 0;
        mif.in_valid  = 1'b1;
        mif.in_data   = d;
        mif.in_parity = p;
        while (!rdy && t < 100) begin
            @(negedge clk);
            rdy = mif.in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!rdy) chk("accept_timeout", rdy, 1);
    endtask

    task automatic send_frame(input int n, input bit push, input bit gaps);
        exp_t e;
        bit   found = 0;
        if (push) begin
            e.err_cnt = 0; e.fidx = 0; e.fdata = 0;
            for (int i = 0; i < c_FL; i++) begin
                if (($countones({fd[i], fp[i]}) % 2) == 1) begin
                    if (!found) begin
                        e.fidx  = i;
                        e.fdata = int'(fd[i]);
                        found   = 1;
                    end
                    e.err_cnt++;
                end
            end
            e.ok = (e.err_cnt == 0) ? 1 : 0;
            if (e.ok == 0) bf_model++;
            e.bf = bf_model;
            q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                mif.in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_word(fd[i], fp[i]);
        end
        if (n == c_FL) chk("report_latency", mif.out_valid, 1);
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q.size() != 0 || hs_pending) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic fill(input logic [3:0] d, input logic p);
        for (int i = 0; i < c_FL; i++) begin
            fd[i] = d;
            fp[i] = p;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.in_valid = 1'b0; mif.in_data = 4'd0; mif.in_parity = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", mif.in_ready, 0);
        chk("rst_out_valid", mif.out_valid, 0);
        chk("rst_err_cnt", mif.out_err_cnt, 0);
        chk("rst_frame_ok", mif.out_frame_ok, 0);
        chk("rst_bad_frames", mif.bad_frames, 0);
`ifdef ERR_CAPTURE_EN
        chk("rst_first_idx", mif.first_err_idx, 0);
        chk("rst_first_data", mif.first_err_data, 0);
`endif
        rst_n = 1'b1;
        chk("ready_delay_low", mif.in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_delay_high", mif.in_ready, 1);

        // Clean frame, then a single error at index 2.
        fill(4'b0011, 1'b0);
        send_frame(c_FL, 1, 0);
        wait_drain();
        fd[2] = 4'b0111;
        send_frame(c_FL, 1, 0);
        wait_drain();

        // Stalled report with the next (all-bad) frame already presented.
        bp_mode = 2;
        fill(4'b0011, 1'b0);
        fd[5] = 4'b1000;
        send_frame(c_FL, 1, 0);
        fill(4'b0001, 1'b0);
        fork
            send_frame(c_FL, 1, 0);
            begin
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    chk("bp_in_ready", mif.in_ready, 0);
                    chk("bp_out_valid", mif.out_valid, 1);
                end
                bp_mode = 0;
            end
        join
        wait_drain();

        // Random words, random gaps and random backpressure.
        bp_mode = 1;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < c_FL; i++) begin
                fd[i] = 4'($urandom_range(0, 15));
                fp[i] = (^fd[i]) ^ ($urandom_range(0, 3) == 0);
            end
            send_frame(c_FL, 1, 1);
        end
        wait_drain();
        bp_mode = 0;
        @(posedge clk);
        #1;

        // Reset in the middle of a frame.
        fill(4'b0011, 1'b0);
        send_frame(4, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", mif.in_ready, 0);
        chk("midrst_out_valid", mif.out_valid, 0);
        chk("midrst_err_cnt", mif.out_err_cnt, 0);
        chk("midrst_frame_ok", mif.out_frame_ok, 0);
        chk("midrst_bad_frames", mif.bad_frames, 0);
        chk("midrst_bad_frames_sat", sif.bad_frames, 0);
        bf_model = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(c_FL, 1, 0);
        wait_drain();

        // Saturation of the 2-bit counter.
        sync_clr = 1'b1;
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        bf_model = 0;
        fill(4'b0001, 1'b0);
        for (int f = 0; f < 5; f++) begin
            send_frame(c_FL, 1, 0);
            wait_drain();
        end

        // sync_clr while a report is pending.
        bp_mode = 2;
        send_frame(c_FL, 1, 0);
        sync_clr = 1'b1;
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        chk("clr_out_valid", mif.out_valid, 0);
        chk("clr_in_ready", mif.in_ready, 1);
        chk("clr_err_cnt", mif.out_err_cnt, 0);
        chk("clr_bad_frames", mif.bad_frames, 0);
        chk("clr_bad_frames_sat", sif.bad_frames, 0);
        void'(q.pop_front());
        bf_model = 0;
        bp_mode = 0;

        // A word presented alongside sync_clr must be dropped.
        mif.in_valid = 1'b1; mif.in_data = 4'b0001; mif.in_parity = 1'b0;
        sync_clr = 1'b1;
        @(posedge clk);
        #1;
        sync_clr = 1'b0;
        mif.in_valid = 1'b0;
        fill(4'b0011, 1'b0);
        send_frame(c_FL, 1, 0);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
